// File: rtl/dac_spi_slave_model.sv
// SPI-slave model of an LTC2624-class quad DAC: oversamples the SPI pins on CLK,
// decodes 32-bit command frames and keeps per-channel input/DAC/power-down state.
module dac_spi_slave_model #(
    parameter int DATA_BITS   = 12,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          SPI_SCK,
    input  logic                          DAC_CS,
    input  logic                          SPI_MOSI,
    input  logic                          DAC_CLR,
    output logic                          DAC_OUT,
    output logic [CHANNELS*DATA_BITS-1:0] DAC_VALUE,
    output logic [CHANNELS-1:0]           PWR_DOWN,
    output logic                          FRAME_VALID,
    output logic                          FRAME_ERROR,
    output logic [3:0]                    LAST_CMD,
    output logic [3:0]                    LAST_ADDR
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   sck_d;
    logic                   cs_d;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;
    logic clr_active;

    logic [31:0]          shift_reg;
    logic [5:0]           bit_cnt;
    logic [DATA_BITS-1:0] input_reg [CHANNELS];
    logic [DATA_BITS-1:0] dac_reg   [CHANNELS];

    logic [3:0]           cmd;
    logic [3:0]           addr;
    logic [DATA_BITS-1:0] data;
    logic                 addr_ok;
    logic [CHANNELS-1:0]  sel;

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign clr_active = ~clr_sync[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign cs_rise    = cs_s & ~cs_d;
    assign cs_fall    = ~cs_s & cs_d;

    // Frame fields are taken from the last 32 bits shifted in; bit 0 is the newest.
    assign cmd  = shift_reg[23:20];
    assign addr = shift_reg[19:16];
    assign data = shift_reg[15 -: DATA_BITS];

    always_comb begin
        sel     = '0;
        addr_ok = (addr == 4'hF) || (int'(addr) < CHANNELS);
        for (int n = 0; n < CHANNELS; n++) begin
            sel[n] = (addr == 4'hF) || (addr == 4'(n));
        end
    end

    always_comb begin
        DAC_VALUE = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            DAC_VALUE[n*DATA_BITS +: DATA_BITS] = dac_reg[n];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_sync    <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '0;
            clr_sync    <= '1;
            sck_d       <= 1'b0;
            cs_d        <= 1'b1;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            DAC_OUT     <= 1'b0;
            FRAME_VALID <= 1'b0;
            FRAME_ERROR <= 1'b0;
            PWR_DOWN    <= '0;
            LAST_CMD    <= '0;
            LAST_ADDR   <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                input_reg[n] <= '0;
                dac_reg[n]   <= '0;
            end
        end else begin
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], DAC_CS};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            clr_sync    <= {clr_sync[SYNC_STAGES-2:0], DAC_CLR};
            sck_d       <= sck_s;
            cs_d        <= cs_s;
            FRAME_VALID <= 1'b0;
            FRAME_ERROR <= 1'b0;

            // A CS rise has cs_s high, so a coincident SCK edge is dropped here.
            if (!cs_s) begin
                if (sck_rise) begin
                    shift_reg <= {shift_reg[30:0], mosi_s};
                    if (bit_cnt != 6'd33) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                if (sck_fall) begin
                    DAC_OUT <= shift_reg[31];
                end
            end

            if (cs_fall) begin
                bit_cnt <= '0;
            end

            if (clr_active) begin
                bit_cnt <= '0;
                for (int n = 0; n < CHANNELS; n++) begin
                    input_reg[n] <= '0;
                    dac_reg[n]   <= '0;
                end
            end else if (cs_rise) begin
                if (bit_cnt < 6'd32 || !addr_ok) begin
                    FRAME_ERROR <= 1'b1;
                end else begin
                    FRAME_VALID <= 1'b1;
                    LAST_CMD    <= cmd;
                    LAST_ADDR   <= addr;
                    case (cmd)
                        4'h0: begin
                            for (int n = 0; n < CHANNELS; n++) begin
                                if (sel[n]) input_reg[n] <= data;
                            end
                        end
                        4'h1: begin
                            for (int n = 0; n < CHANNELS; n++) begin
                                if (sel[n]) begin
                                    dac_reg[n]  <= input_reg[n];
                                    PWR_DOWN[n] <= 1'b0;
                                end
                            end
                        end
                        4'h2: begin
                            // Every DAC takes its input register as it stands after this write.
                            for (int n = 0; n < CHANNELS; n++) begin
                                input_reg[n] <= sel[n] ? data : input_reg[n];
                                dac_reg[n]   <= sel[n] ? data : input_reg[n];
                            end
                            PWR_DOWN <= '0;
                        end
                        4'h3: begin
                            for (int n = 0; n < CHANNELS; n++) begin
                                if (sel[n]) begin
                                    input_reg[n] <= data;
                                    dac_reg[n]   <= data;
                                    PWR_DOWN[n]  <= 1'b0;
                                end
                            end
                        end
                        4'h4: PWR_DOWN <= PWR_DOWN | sel;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_slave_model.sv
// Bench for dac_spi_slave_model: a 12-bit/4-channel and a 16-bit/8-channel instance
// share one SPI bus and are checked against a frame-level reference model.
module tb_dac_spi_slave_model;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    logic clr = 1'b1;

    logic         dout0, fv0, fe0;
    logic [47:0]  dv0;
    logic [3:0]   pd0, lc0, la0;
    logic         dout1, fv1, fe1;
    logic [127:0] dv1;
    logic [7:0]   pd1;
    logic [3:0]   lc1, la1;

    always #5 clk = ~clk;

    dac_spi_slave_model #(.DATA_BITS(12), .CHANNELS(4), .SYNC_STAGES(2)) dut0 (
        .CLK(clk), .RST(rst), .SPI_SCK(sck), .DAC_CS(cs), .SPI_MOSI(mosi), .DAC_CLR(clr),
        .DAC_OUT(dout0), .DAC_VALUE(dv0), .PWR_DOWN(pd0), .FRAME_VALID(fv0),
        .FRAME_ERROR(fe0), .LAST_CMD(lc0), .LAST_ADDR(la0)
    );

    dac_spi_slave_model #(.DATA_BITS(16), .CHANNELS(8), .SYNC_STAGES(2)) dut1 (
        .CLK(clk), .RST(rst), .SPI_SCK(sck), .DAC_CS(cs), .SPI_MOSI(mosi), .DAC_CLR(clr),
        .DAC_OUT(dout1), .DAC_VALUE(dv1), .PWR_DOWN(pd1), .FRAME_VALID(fv1),
        .FRAME_ERROR(fe1), .LAST_CMD(lc1), .LAST_ADDR(la1)
    );

    int checks = 0;
    int errors = 0;
    int vcnt [2];
    int ecnt [2];

    // Reference state: values right-justified, indexed [instance][channel].
    logic [15:0] m_in  [2][16];
    logic [15:0] m_dac [2][16];
    logic [15:0] m_pd  [2];
    logic [3:0]  m_cmd [2];
    logic [3:0]  m_addr[2];
    bit          hist[$];
    logic [63:0] so_cap;

    always @(negedge clk) begin
        if (fv0) vcnt[0]++;
        if (fe0) ecnt[0]++;
        if (fv1) vcnt[1]++;
        if (fe1) ecnt[1]++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 16; c++) begin
                m_in[k][c]  = '0;
                m_dac[k][c] = '0;
            end
            m_pd[k]   = '0;
            m_cmd[k]  = '0;
            m_addr[k] = '0;
        end
        hist.delete();
    endtask

    // pulse: 0 none, 1 FRAME_VALID, 2 FRAME_ERROR
    task automatic model_frame(input int k, input logic [31:0] w, input int nbits,
                               input bit clr_hit, output int pulse);
        int db;
        int ch;
        logic [3:0] c;
        logic [3:0] a;
        logic [15:0] d;
        int targets[$];
        db = (k == 0) ? 12 : 16;
        ch = (k == 0) ? 4 : 8;
        pulse = 0;
        if (clr_hit) begin
            for (int i = 0; i < 16; i++) begin
                m_in[k][i]  = '0;
                m_dac[k][i] = '0;
            end
            return;
        end
        c = w[23:20];
        a = w[19:16];
        d = w[15:0] >> (16 - db);
        if (nbits < 32 || (a != 4'hF && int'(a) >= ch)) begin
            pulse = 2;
            return;
        end
        pulse = 1;
        m_cmd[k]  = c;
        m_addr[k] = a;
        if (a == 4'hF) begin
            for (int i = 0; i < ch; i++) targets.push_back(i);
        end else begin
            targets.push_back(int'(a));
        end
        case (c)
            4'h0: foreach (targets[t]) m_in[k][targets[t]] = d;
            4'h1: foreach (targets[t]) begin
                m_dac[k][targets[t]] = m_in[k][targets[t]];
                m_pd[k][targets[t]]  = 1'b0;
            end
            4'h2: begin
                foreach (targets[t]) m_in[k][targets[t]] = d;
                for (int i = 0; i < ch; i++) m_dac[k][i] = m_in[k][i];
                m_pd[k] = '0;
            end
            4'h3: foreach (targets[t]) begin
                m_in[k][targets[t]]  = d;
                m_dac[k][targets[t]] = d;
                m_pd[k][targets[t]]  = 1'b0;
            end
            4'h4: foreach (targets[t]) m_pd[k][targets[t]] = 1'b1;
            default: ;
        endcase
    endtask

    task automatic check_all(input int p0, input int p1);
        logic [47:0]  e0;
        logic [127:0] e1;
        for (int n = 0; n < 4; n++) e0[n*12 +: 12] = m_dac[0][n][11:0];
        for (int n = 0; n < 8; n++) e1[n*16 +: 16] = m_dac[1][n];
        check("dac_value0", dv0, e0);
        check("pwr_down0", pd0, m_pd[0][3:0]);
        check("last_cmd0", lc0, m_cmd[0]);
        check("last_addr0", la0, m_addr[0]);
        check("valid_pulses0", vcnt[0], (p0 == 1) ? 1 : 0);
        check("error_pulses0", ecnt[0], (p0 == 2) ? 1 : 0);
        check("dac_value1", dv1, e1);
        check("pwr_down1", pd1, m_pd[1][7:0]);
        check("last_cmd1", lc1, m_cmd[1]);
        check("last_addr1", la1, m_addr[1]);
        check("valid_pulses1", vcnt[1], (p1 == 1) ? 1 : 0);
        check("error_pulses1", ecnt[1], (p1 == 2) ? 1 : 0);
    endtask

    // Sends word[nbits-1:0] MSB first; clr_at >= 0 drops DAC_CLR before that bit
    // and holds it low through the CS rise.
    task automatic send_frame(input logic [63:0] word, input int nbits, input int clr_at);
        int  n;
        bit  e;
        so_cap = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            if (clr_at == nbits - 1 - i) clr = 1'b0;
            repeat (4) @(negedge clk);
            n = hist.size();
            e = (n >= 32) ? hist[n-32] : 1'b0;
            check("dac_out0", dout0, e);
            check("dac_out1", dout1, e);
            so_cap = {so_cap[62:0], dout0};
            sck = 1'b1;
            hist.push_back(word[i]);
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        if (clr_at >= 0) begin
            clr = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [63:0] word, input int nbits, input int clr_at);
        int p0;
        int p1;
        vcnt[0] = 0; ecnt[0] = 0; vcnt[1] = 0; ecnt[1] = 0;
        send_frame(word, nbits, clr_at);
        model_frame(0, word[31:0], nbits, clr_at >= 0, p0);
        model_frame(1, word[31:0], nbits, clr_at >= 0, p1);
        check_all(p0, p1);
    endtask

    typedef struct {
        logic [63:0] word;
        int          nbits;
        int          pulse;
        logic [47:0] dv;
        logic [3:0]  pd;
        logic [3:0]  cmd;
        logic [3:0]  addr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [63:0] w;
        int nb;
        int ca;
        int r;
        logic [3:0] rc;
        logic [3:0] ra;

        // Expectations for the 12-bit/4-channel instance, applied in order from reset.
        tbl[0]  = '{64'h0032ABC0,   32, 1, 48'h000ABC000000, 4'h0, 4'h3, 4'h2};
        tbl[1]  = '{64'h000F1230,   32, 1, 48'h000ABC000000, 4'h0, 4'h0, 4'hF};
        tbl[2]  = '{64'h00110000,   32, 1, 48'h000ABC123000, 4'h0, 4'h1, 4'h1};
        tbl[3]  = '{64'h00330FFF,   31, 2, 48'h000ABC123000, 4'h0, 4'h1, 4'h1};
        tbl[4]  = '{64'hA500307FF0, 40, 1, 48'h000ABC1237FF, 4'h0, 4'h3, 4'h0};
        tbl[5]  = '{64'h00430000,   32, 1, 48'h000ABC1237FF, 4'h8, 4'h4, 4'h3};
        tbl[6]  = '{64'h00330010,   32, 1, 48'h001ABC1237FF, 4'h0, 4'h3, 4'h3};
        tbl[7]  = '{64'h00355550,   32, 2, 48'h001ABC1237FF, 4'h0, 4'h3, 4'h3};
        tbl[8]  = '{64'h004F0000,   32, 1, 48'h001ABC1237FF, 4'hF, 4'h4, 4'hF};
        tbl[9]  = '{64'h00214560,   32, 1, 48'h0011234567FF, 4'h0, 4'h2, 4'h1};
        tbl[10] = '{64'h00F00000,   32, 1, 48'h0011234567FF, 4'h0, 4'hF, 4'h0};

        model_reset();
        vcnt[0] = 0; ecnt[0] = 0; vcnt[1] = 0; ecnt[1] = 0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all(0, 0);
        check("reset_dac_out0", dout0, 1'b0);
        check("reset_dac_out1", dout1, 1'b0);

        for (int i = 0; i < 11; i++) begin
            run_frame(tbl[i].word, tbl[i].nbits, -1);
            check("tbl_dac_value", dv0, tbl[i].dv);
            check("tbl_pwr_down", pd0, tbl[i].pd);
            check("tbl_last_cmd", lc0, tbl[i].cmd);
            check("tbl_last_addr", la0, tbl[i].addr);
            check("tbl_valid", vcnt[0], (tbl[i].pulse == 1) ? 1 : 0);
            check("tbl_error", ecnt[0], (tbl[i].pulse == 2) ? 1 : 0);
        end

        // Wide instance: address 7 decodes with full 16-bit data, address 8 is rejected.
        run_frame(64'h0037BEEF, 32, -1);
        check("wide_ch7", dv1[7*16 +: 16], 16'hBEEF);
        check("wide_valid", vcnt[1], 1);
        check("narrow_addr7_error", ecnt[0], 1);
        run_frame(64'h00381234, 32, -1);
        check("wide_addr8_error", ecnt[1], 1);
        check("wide_addr8_no_valid", vcnt[1], 0);
        check("wide_last_addr", la1, 4'h7);

        // Daisy chain: the bits seen before each SCK rise of B replay frame A.
        run_frame(64'hC3F0A55A, 32, -1);
        run_frame(64'h69F30000, 32, -1);
        check("daisy_echo", so_cap[31:0], 32'hC3F0A55A);

        // Clear mid-frame: registers zeroed, power-down kept, CS rise swallowed.
        run_frame(64'h0030FFF0, 32, -1);
        run_frame(64'h00410000, 32, -1);
        check("pd_before_clr", pd0, 4'b0010);
        run_frame(64'h00325550, 32, 10);
        check("clr_dac_value", dv0, 48'h0);
        check("clr_pd_kept", pd0, 4'b0010);
        check("clr_no_valid", vcnt[0], 0);
        check("clr_no_error", ecnt[0], 0);
        run_frame(64'h00325550, 32, -1);
        check("after_clr_value", dv0, 48'h000555000000);
        check("after_clr_valid", vcnt[0], 1);

        // Reset in the middle of a frame abandons it.
        vcnt[0] = 0; ecnt[0] = 0; vcnt[1] = 0; ecnt[1] = 0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        rst = 1'b1;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        model_reset();
        check_all(0, 0);
        check("rst_mid_dac_out0", dout0, 1'b0);
        check("rst_mid_dac_out1", dout1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 6);
            rc = (r == 6) ? 4'hF : 4'(r);
            ra = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 9));
            w  = {$urandom, $urandom};
            w[23:16] = {rc, ra};
            r  = $urandom_range(0, 9);
            nb = (r == 0) ? $urandom_range(8, 31) : (r == 1) ? $urandom_range(33, 40) : 32;
            ca = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
            run_frame(w, nb, ca);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
